// File: rtl/adder_result_accumulator.sv
// adder_result_accumulator: sums SAMPLES 5-bit adder results per frame.
// The frame total is presented on a registered valid/ready output.
module adder_result_accumulator #(
    parameter int SAMPLES = 8,
    parameter int ACC_W   = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_sum,
    input  logic             in_cout,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic [7:0]       out_count,
    output logic             out_ovf
);
    typedef enum logic {ACCUM, DONE} state_t;
    state_t           state_q, state_d;
    logic [ACC_W-1:0] total_q, total_d;
    logic [7:0]       count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   in_value, sum;
    assign in_value  = {{(ACC_W-4){1'b0}}, in_cout, in_sum};
    assign sum       = {1'b0, total_q} + in_value;
    // Handshake outputs decode from state only, never from in_valid/out_ready.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign out_total = total_q;
    assign out_count = count_q;
    assign out_ovf   = ovf_q;
    always_comb begin
        state_d = state_q;
        total_d = total_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clear || (state_q == DONE && out_ready)) begin
            state_d = ACCUM;
            total_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (state_q == ACCUM && in_valid) begin
            total_d = sum[ACC_W-1:0];
            ovf_d   = ovf_q | sum[ACC_W];
            count_d = count_q + 8'd1;
            state_d = (count_q == 8'(SAMPLES - 1)) ? DONE : ACCUM;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            total_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_adder_result_accumulator.sv
// tb_adder_result_accumulator: directed frames against hand-computed totals,
// with a second narrow-accumulator instance to exercise wrap and overflow.
module tb_adder_result_accumulator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_sum = 4'd0;
    logic        in_cout = 1'b0;
    logic        clear = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, out_ovf;
    logic [11:0] out_total;
    logic [7:0]  out_count;
    logic        n_in_ready, n_out_valid, n_out_ovf;
    logic [6:0]  n_out_total;
    logic [7:0]  n_out_count;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adder_result_accumulator #(.SAMPLES(8), .ACC_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_cout(in_cout), .clear(clear), .out_valid(out_valid),
        .out_ready(out_ready), .out_total(out_total), .out_count(out_count), .out_ovf(out_ovf)
    );

    adder_result_accumulator #(.SAMPLES(8), .ACC_W(7)) dut_n (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_sum(in_sum), .in_cout(in_cout), .clear(clear), .out_valid(n_out_valid),
        .out_ready(out_ready), .out_total(n_out_total), .out_count(n_out_count), .out_ovf(n_out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] v);
        in_valid = 1'b1;
        {in_cout, in_sum} = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [4:0] gap_vals [8];
        gap_vals = '{5'd5, 5'd0, 5'd17, 5'd31, 5'd2, 5'd9, 5'd3, 5'd1};
        #1;
        check("rst_total", out_total, 0);
        check("rst_count", out_count, 0);
        check("rst_ovf", out_ovf, 0);
        check("rst_out_valid", out_valid, 0);
        #11 rst_n = 1'b1;
        tick();
        check("rel_in_ready", in_ready, 1);

        for (int i = 0; i < 7; i++) send(5'd31);
        check("f1_not_done", out_valid, 0);
        check("f1_count7", out_count, 7);
        send(5'd31);
        check("f1_out_valid", out_valid, 1);
        check("f1_total", out_total, 248);
        check("f1_count", out_count, 8);
        check("f1_ovf", out_ovf, 0);
        check("f1_in_ready", in_ready, 0);
        check("n_total", n_out_total, 120);
        check("n_ovf", n_out_ovf, 1);
        check("n_count", n_out_count, 8);
        check("n_out_valid", n_out_valid, 1);
        drain();
        check("f1_clr_total", out_total, 0);
        check("f1_clr_in_ready", in_ready, 1);
        check("n_clr_ovf", n_out_ovf, 0);

        for (int i = 1; i <= 8; i++) send(5'(i));
        check("bp_total", out_total, 36);
        in_valid = 1'b1;
        {in_cout, in_sum} = 5'd5;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_total", out_total, 36);
            check("bp_hold_count", out_count, 8);
            check("bp_hold_in_ready", in_ready, 0);
            check("bp_hold_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        drain();
        check("bp_rel_total", out_total, 0);
        check("bp_rel_count", out_count, 0);
        check("bp_rel_in_ready", in_ready, 1);
        check("bp_rel_out_valid", out_valid, 0);

        for (int i = 0; i < 8; i++) begin
            send(gap_vals[i]);
            tick();
            check("gap_count", out_count, i + 1);
        end
        check("gap_total", out_total, 68);
        check("gap_out_valid", out_valid, 1);
        drain();

        for (int i = 0; i < 3; i++) send(5'd10);
        check("clr_pre_total", out_total, 30);
        clear = 1'b1;
        send(5'd7);
        clear = 1'b0;
        check("clr_total", out_total, 0);
        check("clr_count", out_count, 0);
        for (int i = 0; i < 8; i++) send(5'd2);
        check("clr_frame_total", out_total, 16);
        check("clr_frame_count", out_count, 8);
        check("clr_frame_valid", out_valid, 1);
        clear = 1'b1;
        out_ready = 1'b1;
        tick();
        clear = 1'b0;
        out_ready = 1'b0;
        check("clr_done_total", out_total, 0);
        check("clr_done_valid", out_valid, 0);

        for (int i = 0; i < 5; i++) send(5'd3);
        check("ar_pre_count", out_count, 5);
        check("ar_pre_total", out_total, 15);
        #2 rst_n = 1'b0;
        #1;
        check("ar_total", out_total, 0);
        check("ar_count", out_count, 0);
        #2 rst_n = 1'b1;
        tick();
        check("ar_in_ready", in_ready, 1);
        for (int i = 0; i < 8; i++) send(5'd4);
        check("ar_frame_total", out_total, 32);
        check("ar_frame_count", out_count, 8);
        check("ar_frame_valid", out_valid, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
